// File: rtl/linear_router_node_if.sv
// Flit link between router nodes: data plus a cs/ready handshake.
// A transfer happens on a rising edge where cs and ready are both high.
interface linear_router_node_if #(
   parameter int unsigned DATA_W = 32
);
   logic [DATA_W-1:0] data;
   logic              cs;
   logic              ready;

   modport master (output data, output cs, input ready);
   modport slave  (input data, input cs, output ready);
endinterface

// File: rtl/linear_router_node.sv
// One hop of a linear router chain: three input FIFOs, destination routing and
// round-robin arbitrated, registered outputs that tolerate downstream stalls.
module linear_router_node #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned NODE_ID = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   linear_router_node_if.slave   in_left,
   linear_router_node_if.slave   in_right,
   linear_router_node_if.slave   in_local,
   linear_router_node_if.master  out_left,
   linear_router_node_if.master  out_right,
   linear_router_node_if.master  out_local,
   output logic [2:0]            overflow_err
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [ADDR_W-1:0] MyAddr = ADDR_W'(NODE_ID);

   // Port index 0 = left, 1 = right, 2 = local, for inputs and outputs alike.
   logic [DATA_W-1:0] in_data [3];
   logic [2:0]        in_cs;
   logic [2:0]        in_ready;
   logic [2:0]        out_ready;

   logic [DATA_W-1:0] mem_q      [3][DEPTH];
   logic [PtrW-1:0]   wr_ptr_q   [3];
   logic [PtrW-1:0]   rd_ptr_q   [3];
   logic [CntW-1:0]   count_q    [3];
   logic [DATA_W-1:0] out_data_q [3];
   logic [2:0]        out_cs_q;
   logic [1:0]        rr_ptr_q   [3];

   logic [DATA_W-1:0] head      [3];
   logic [ADDR_W-1:0] dest      [3];
   logic [2:0]        req       [3];
   logic [1:0]        grant_idx [3];
   logic [2:0]        grant_vld;
   logic [2:0]        push;
   logic [2:0]        pop;

   assign in_data[0] = in_left.data;
   assign in_data[1] = in_right.data;
   assign in_data[2] = in_local.data;
   assign in_cs      = {in_local.cs, in_right.cs, in_left.cs};
   assign out_ready  = {out_local.ready, out_right.ready, out_left.ready};

   assign in_left.ready  = in_ready[0];
   assign in_right.ready = in_ready[1];
   assign in_local.ready = in_ready[2];

   assign out_left.data  = out_data_q[0];
   assign out_right.data = out_data_q[1];
   assign out_local.data = out_data_q[2];
   assign out_left.cs    = out_cs_q[0];
   assign out_right.cs   = out_cs_q[1];
   assign out_local.cs   = out_cs_q[2];

   function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] k);
      logic [2:0] s;
      s = {1'b0, base} + {1'b0, k};
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

   always_comb begin
      for (int o = 0; o < 3; o++) req[o] = '0;
      for (int i = 0; i < 3; i++) begin
         in_ready[i] = (count_q[i] != CntW'(DEPTH));
         push[i]     = in_cs[i] & in_ready[i];
         head[i]     = mem_q[i][rd_ptr_q[i]];
         dest[i]     = head[i][DATA_W-1 -: ADDR_W];
         if (count_q[i] != '0) begin
            if (dest[i] == MyAddr)     req[2][i] = 1'b1;
            else if (dest[i] > MyAddr) req[1][i] = 1'b1;
            else                       req[0][i] = 1'b1;
         end
      end
   end

   // Each head requests one output only, so grants from different outputs never collide.
   always_comb begin
      pop = '0;
      for (int o = 0; o < 3; o++) begin
         grant_vld[o] = 1'b0;
         grant_idx[o] = '0;
         if (!out_cs_q[o] || out_ready[o]) begin
            for (int k = 0; k < 3; k++) begin
               if (!grant_vld[o] && req[o][rr_idx(rr_ptr_q[o], 2'(k))]) begin
                  grant_vld[o] = 1'b1;
                  grant_idx[o] = rr_idx(rr_ptr_q[o], 2'(k));
               end
            end
         end
         if (grant_vld[o]) pop[grant_idx[o]] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            wr_ptr_q[i]   <= '0;
            rd_ptr_q[i]   <= '0;
            count_q[i]    <= '0;
            out_data_q[i] <= '0;
            rr_ptr_q[i]   <= '0;
         end
         out_cs_q     <= '0;
         overflow_err <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
            if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
            count_q[i] <= count_q[i] + CntW'(push[i]) - CntW'(pop[i]);
            if (in_cs[i] && !in_ready[i]) overflow_err[i] <= 1'b1;
         end
         for (int o = 0; o < 3; o++) begin
            if (grant_vld[o]) begin
               out_data_q[o] <= head[grant_idx[o]];
               out_cs_q[o]   <= 1'b1;
               rr_ptr_q[o]   <= rr_idx(grant_idx[o], 2'd1);
            end else if (out_ready[o]) begin
               out_cs_q[o] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_linear_router_node.sv
// Self-checking bench for linear_router_node: routing table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_linear_router_node;
   localparam int DEPTH = 4;
   localparam int NID   = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] i_data [3];
   logic [2:0]  i_cs;
   logic [2:0]  o_ready;
   logic [2:0]  i_ready;
   logic [31:0] o_data [3];
   logic [2:0]  o_cs;
   logic [2:0]  err;

   logic [31:0] d2_data;
   logic        d2_cs;
   logic        d2_ready;
   logic [31:0] d2_odata;
   logic        d2_ocs;
   logic [2:0]  err2;

   int total = 0;
   int bad   = 0;

   linear_router_node_if #(.DATA_W(32)) il(), ir(), ic(), ol(), orr(), oc();
   linear_router_node_if #(.DATA_W(32)) jl(), jr(), jc(), pl(), pr(), pc();

   assign il.data = i_data[0];
   assign ir.data = i_data[1];
   assign ic.data = i_data[2];
   assign il.cs   = i_cs[0];
   assign ir.cs   = i_cs[1];
   assign ic.cs   = i_cs[2];
   assign i_ready = {ic.ready, ir.ready, il.ready};
   assign o_data[0] = ol.data;
   assign o_data[1] = orr.data;
   assign o_data[2] = oc.data;
   assign o_cs      = {oc.cs, orr.cs, ol.cs};
   assign ol.ready  = o_ready[0];
   assign orr.ready = o_ready[1];
   assign oc.ready  = o_ready[2];

   assign jl.data = '0;
   assign jl.cs   = 1'b0;
   assign jr.data = '0;
   assign jr.cs   = 1'b0;
   assign jc.data = d2_data;
   assign jc.cs   = d2_cs;
   assign d2_ready = jc.ready;
   assign d2_odata = pc.data;
   assign d2_ocs   = pc.cs;
   assign pl.ready = 1'b1;
   assign pr.ready = 1'b1;
   assign pc.ready = 1'b1;

   linear_router_node #(.DATA_W(32), .ADDR_W(4), .DEPTH(DEPTH), .NODE_ID(NID)) dut (
      .clk(clk), .reset(reset),
      .in_left(il), .in_right(ir), .in_local(ic),
      .out_left(ol), .out_right(orr), .out_local(oc),
      .overflow_err(err)
   );

   linear_router_node #(.DATA_W(32), .ADDR_W(4), .DEPTH(2), .NODE_ID(NID)) dut2 (
      .clk(clk), .reset(reset),
      .in_left(jl), .in_right(jr), .in_local(jc),
      .out_left(pl), .out_right(pr), .out_local(pc),
      .overflow_err(err2)
   );

   // Reference model: one queue per input FIFO plus the three output registers.
   logic [31:0] mq [3][$];
   logic [31:0] m_odata [3];
   bit   [2:0]  m_ocs;
   int          m_rr [3];
   bit   [2:0]  m_err;

   function automatic logic [31:0] mk(input int dst, input logic [31:0] payload);
      logic [3:0] d;
      d = 4'(dst);
      return {d, payload[27:0]};
   endfunction

   function automatic int route(input logic [31:0] f);
      int d;
      d = int'(f[31:28]);
      if (d == NID) return 2;
      return (d > NID) ? 1 : 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mq[i].delete();
         m_odata[i] = '0;
         m_rr[i] = 0;
      end
      m_ocs = '0;
      m_err = '0;
   endtask

   task automatic model_step();
      bit   [2:0]  ncs;
      logic [31:0] nd [3];
      int          nrr [3];
      bit   [2:0]  popm;
      bit   [2:0]  acc;
      popm = '0;
      for (int i = 0; i < 3; i++) acc[i] = i_cs[i] && (mq[i].size() < DEPTH);
      for (int o = 0; o < 3; o++) begin
         ncs[o] = m_ocs[o];
         nd[o]  = m_odata[o];
         nrr[o] = m_rr[o];
         if (!m_ocs[o] || o_ready[o]) begin
            ncs[o] = 1'b0;
            for (int k = 0; k < 3; k++) begin
               int s;
               s = (m_rr[o] + k) % 3;
               if (!ncs[o] && mq[s].size() > 0 && route(mq[s][0]) == o) begin
                  ncs[o]  = 1'b1;
                  nd[o]   = mq[s][0];
                  popm[s] = 1'b1;
                  nrr[o]  = (s + 1) % 3;
               end
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (i_cs[i] && !acc[i]) m_err[i] = 1'b1;
         if (popm[i]) void'(mq[i].pop_front());
         if (acc[i]) mq[i].push_back(i_data[i]);
      end
      m_ocs = ncs;
      for (int o = 0; o < 3; o++) begin
         m_odata[o] = nd[o];
         m_rr[o] = nrr[o];
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_cs = '0;
      d2_cs = 1'b0;
      o_ready = 3'b111;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic compare_model();
      for (int o = 0; o < 3; o++) begin
         check($sformatf("rand out%0d cs", o), 32'(o_cs[o]), 32'(m_ocs[o]));
         if (m_ocs[o]) check($sformatf("rand out%0d data", o), o_data[o], m_odata[o]);
         check($sformatf("rand in%0d ready", o), 32'(i_ready[o]),
               32'(mq[o].size() < DEPTH));
      end
      check("rand overflow_err", 32'(err), 32'(m_err));
   endtask

   typedef struct {
      int          src;
      logic [31:0] data;
      int          port;
   } vec_t;

   vec_t vecs [8];
   logic [31:0] fa, fb, fc;
   logic [31:0] fl [6];

   initial begin
      for (int i = 0; i < 3; i++) i_data[i] = '0;
      d2_data = '0;
      do_reset();

      check("reset out_cs", 32'(o_cs), 32'h0);
      for (int o = 0; o < 3; o++) check("reset out_data", o_data[o], 32'h0);
      check("reset in_ready", 32'(i_ready), 32'h7);
      check("reset overflow_err", 32'(err), 32'h0);

      // Routing table, node address 2: one flit per vector, every output ready.
      vecs[0] = '{2, 32'h5000_0049, 1};
      vecs[1] = '{0, mk(2, 32'h11), 2};
      vecs[2] = '{0, mk(0, 32'h22), 0};
      vecs[3] = '{1, mk(7, 32'h33), 1};
      vecs[4] = '{1, mk(1, 32'h44), 0};
      vecs[5] = '{2, mk(2, 32'h55), 2};
      vecs[6] = '{2, mk(15, 32'h66), 1};
      vecs[7] = '{0, mk(3, 32'h77), 1};
      for (int v = 0; v < 8; v++) begin
         do_reset();
         i_cs[vecs[v].src] = 1'b1;
         i_data[vecs[v].src] = vecs[v].data;
         tick();
         i_cs = '0;
         check($sformatf("vec%0d latency", v), 32'(o_cs), 32'h0);
         tick();
         check($sformatf("vec%0d route", v), 32'(o_cs), 32'(3'b001 << vecs[v].port));
         check($sformatf("vec%0d data", v), o_data[vecs[v].port], vecs[v].data);
         tick();
         check($sformatf("vec%0d one cycle", v), 32'(o_cs), 32'h0);
      end

      // Left and right contend for local; right wins the following contention.
      do_reset();
      fa = mk(2, 32'hA); fb = mk(2, 32'hB); fc = mk(2, 32'hC);
      i_cs = 3'b011; i_data[0] = fa; i_data[1] = fb;
      tick();
      i_cs = 3'b001; i_data[0] = fc;
      tick();
      i_cs = '0;
      check("rr first", o_data[2], fa);
      check("rr first cs", 32'(o_cs[2]), 32'h1);
      tick();
      check("rr second", o_data[2], fb);
      tick();
      check("rr third", o_data[2], fc);
      check("rr third cs", 32'(o_cs[2]), 32'h1);
      tick();
      check("rr drained", 32'(o_cs), 32'h0);

      // Backpressure on right: DEPTH+1 flits accepted, next one refused.
      do_reset();
      o_ready = 3'b101;
      for (int n = 0; n < 6; n++) begin
         fl[n] = mk(7, 32'(n + 32'h100));
         i_cs[2] = 1'b1;
         i_data[2] = fl[n];
         check($sformatf("bp ready %0d", n), 32'(i_ready[2]), (n < 5) ? 32'h1 : 32'h0);
         if (n == 5) check("bp err before", 32'(err), 32'h0);
         tick();
      end
      i_cs = '0;
      check("bp err sticky", 32'(err), 32'h4);
      check("bp held cs", 32'(o_cs[1]), 32'h1);
      tick();
      check("bp held data", o_data[1], fl[0]);
      o_ready = 3'b111;
      for (int n = 0; n < 5; n++) begin
         check($sformatf("bp drain cs %0d", n), 32'(o_cs[1]), 32'h1);
         check($sformatf("bp drain data %0d", n), o_data[1], fl[n]);
         tick();
      end
      check("bp drained", 32'(o_cs[1]), 32'h0);
      check("bp err kept", 32'(err), 32'h4);

      // All three outputs fire on the same edge.
      do_reset();
      i_cs = 3'b111;
      i_data[0] = mk(5, 32'h1); i_data[1] = mk(1, 32'h2); i_data[2] = mk(2, 32'h3);
      tick();
      i_cs = '0;
      tick();
      check("par cs", 32'(o_cs), 32'h7);
      check("par right", o_data[1], mk(5, 32'h1));
      check("par left", o_data[0], mk(1, 32'h2));
      check("par local", o_data[2], mk(2, 32'h3));

      // Reset mid-operation discards buffered and in-flight flits.
      do_reset();
      o_ready = 3'b000;
      for (int n = 0; n < 7; n++) begin
         i_cs[0] = 1'b1;
         i_data[0] = mk(5, 32'(n));
         tick();
      end
      i_cs = '0;
      check("mid cs before", 32'(o_cs[1]), 32'h1);
      #2 reset = 1'b1;
      #1;
      check("mid async cs", 32'(o_cs), 32'h0);
      check("mid ready", 32'(i_ready), 32'h7);
      check("mid err", 32'(err), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      o_ready = 3'b111;
      for (int n = 0; n < 3; n++) begin
         tick();
         check($sformatf("mid no replay %0d", n), 32'(o_cs), 32'h0);
      end

      // DEPTH=2 instance: continuous push and pop through local.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         d2_cs = 1'b1;
         d2_data = mk(2, 32'(c + 32'h200));
         tick();
         check($sformatf("wrap ready %0d", c), 32'(d2_ready), 32'h1);
         check($sformatf("wrap count %0d", c), 32'(dut2.count_q[2]), 32'h1);
         if (c > 0) begin
            check($sformatf("wrap cs %0d", c), 32'(d2_ocs), 32'h1);
            check($sformatf("wrap data %0d", c), d2_odata, mk(2, 32'(c - 1 + 32'h200)));
         end
      end
      d2_cs = 1'b0;
      tick();
      check("wrap last", d2_odata, mk(2, 32'(9 + 32'h200)));
      tick();
      check("wrap idle", 32'(d2_ocs), 32'h0);

      // Randomized traffic against the reference model.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 3; i++) begin
            i_cs[i] = ($urandom_range(0, 99) < 55);
            i_data[i] = mk(int'($urandom_range(0, 7)), $urandom);
            o_ready[i] = ($urandom_range(0, 99) < 65);
         end
         tick();
         compare_model();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
